// File: rtl/dmx_frame_scheduler_if.sv
// Control/status bundle between the register block, the frame scheduler and
// dmx_out. The register side (and dmx_out busy) drives through "master";
// the scheduler itself connects through "slave".
interface dmx_frame_scheduler_if #(
    parameter int PERIOD_WIDTH = 24,
    parameter int COUNT_WIDTH  = 16
);
    logic                    i_enable;
    logic [PERIOD_WIDTH-1:0] i_period;
    logic                    i_manual_strobe;
    logic                    i_swap_req;
    logic                    i_clear_flags;
    logic                    i_dmx_busy;
    logic                    o_start_strobe;
    logic                    o_bank;
    logic                    o_swap_pending;
    logic                    o_manual_pending;
    logic [COUNT_WIDTH-1:0]  o_frame_count;
    logic                    o_overrun;
    logic                    o_fault;
    logic [1:0]              dbg_state;

    modport master (
        output i_enable, i_period, i_manual_strobe, i_swap_req, i_clear_flags, i_dmx_busy,
        input  o_start_strobe, o_bank, o_swap_pending, o_manual_pending, o_frame_count,
               o_overrun, o_fault, dbg_state
    );

    modport slave (
        input  i_enable, i_period, i_manual_strobe, i_swap_req, i_clear_flags, i_dmx_busy,
        output o_start_strobe, o_bank, o_swap_pending, o_manual_pending, o_frame_count,
               o_overrun, o_fault, dbg_state
    );
endinterface

// File: rtl/dmx_frame_scheduler.sv
// DMX frame scheduler: issues the dmx_out start strobe from a periodic tick or
// a latched manual request, owns the frame-buffer bank select (swapped only at
// frame start) and reports frame count, overrun and start-timeout faults.
//
// Start/busy handshake: o_start_strobe is a single-cycle pulse, issued only
// from IDLE while i_dmx_busy is low. dmx_out acknowledges by raising
// i_dmx_busy within ACK_TIMEOUT clocks and drops it when the frame is done;
// the falling edge marks a completed frame. There is no back-pressure beyond
// busy: a request that cannot start is either held (manual) or dropped and
// flagged (periodic tick).
module dmx_frame_scheduler #(
    parameter int PERIOD_WIDTH = 24,
    parameter int ACK_TIMEOUT  = 16,
    parameter int MIN_GAP      = 8,
    parameter int COUNT_WIDTH  = 16
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    dmx_frame_scheduler_if.slave bus
);
    localparam int TIMER_MAX   = (ACK_TIMEOUT > MIN_GAP) ? ACK_TIMEOUT : MIN_GAP;
    localparam int TIMER_WIDTH = $clog2(TIMER_MAX + 1);
    localparam logic [TIMER_WIDTH-1:0] ACK_LAST = TIMER_WIDTH'(ACK_TIMEOUT - 1);
    localparam logic [TIMER_WIDTH-1:0] GAP_LAST = TIMER_WIDTH'(MIN_GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_RUNNING  = 2'd2,
        ST_GAP      = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [TIMER_WIDTH-1:0]  timer_q, timer_d;
    logic [PERIOD_WIDTH-1:0] period_cnt;
    logic                    active, tick, request;
    logic                    go, fault_set, frame_done;
    logic                    strobe_q, bank_q, swap_q, manual_q, overrun_q, fault_q;
    logic [COUNT_WIDTH-1:0]  count_q;

    // A tick fires on the first enabled cycle and then every i_period clocks.
    assign active  = bus.i_enable & (bus.i_period != '0);
    assign tick    = active & (period_cnt == '0);
    assign request = tick | manual_q | bus.i_manual_strobe;

    // Period down-counter; new i_period values are picked up at reload only.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            period_cnt <= '0;
        end else if (!active) begin
            period_cnt <= '0;
        end else if (tick) begin
            period_cnt <= bus.i_period - PERIOD_WIDTH'(1);
        end else begin
            period_cnt <= period_cnt - PERIOD_WIDTH'(1);
        end
    end

    // FSM state and shared ack/gap timer registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // FSM next-state: start from IDLE, wait for ack, run, then enforce the gap.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        go         = 1'b0;
        fault_set  = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (request && !bus.i_dmx_busy) begin
                    go      = 1'b1;
                    state_d = ST_WAIT_ACK;
                    timer_d = '0;
                end
            end
            ST_WAIT_ACK: begin
                if (bus.i_dmx_busy) begin
                    state_d = ST_RUNNING;
                end else if (timer_q == ACK_LAST) begin
                    fault_set = 1'b1;
                    state_d   = ST_GAP;
                    timer_d   = '0;
                end else begin
                    timer_d = timer_q + TIMER_WIDTH'(1);
                end
            end
            ST_RUNNING: begin
                if (!bus.i_dmx_busy) begin
                    frame_done = 1'b1;
                    state_d    = ST_GAP;
                    timer_d    = '0;
                end
            end
            ST_GAP: begin
                if (timer_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TIMER_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Strobe, request latches, bank select, frame counter and sticky flags.
    // A tick that cannot start a frame is dropped and flagged; sets beat clears.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            strobe_q  <= 1'b0;
            manual_q  <= 1'b0;
            swap_q    <= 1'b0;
            bank_q    <= 1'b0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            strobe_q <= go;
            manual_q <= (manual_q | bus.i_manual_strobe) & ~go;
            if (go) begin
                if (swap_q || bus.i_swap_req) begin
                    bank_q <= ~bank_q;
                end
                swap_q <= 1'b0;
            end else if (bus.i_swap_req) begin
                swap_q <= 1'b1;
            end
            if (frame_done) begin
                count_q <= count_q + COUNT_WIDTH'(1);
            end
            if (tick && !go) begin
                overrun_q <= 1'b1;
            end else if (bus.i_clear_flags) begin
                overrun_q <= 1'b0;
            end
            if (fault_set) begin
                fault_q <= 1'b1;
            end else if (bus.i_clear_flags) begin
                fault_q <= 1'b0;
            end
        end
    end

    assign bus.o_start_strobe   = strobe_q;
    assign bus.o_bank           = bank_q;
    assign bus.o_swap_pending   = swap_q;
    assign bus.o_manual_pending = manual_q;
    assign bus.o_frame_count    = count_q;
    assign bus.o_overrun        = overrun_q;
    assign bus.o_fault          = fault_q;
    assign bus.dbg_state        = state_q;
endmodule
